cc_job_scheduler: RTL and testbench

Sequencing and arbitration controller that shares one combinational sort/normalise/equation (CC) datapath between two requesters. Each job carries six 4-bit operands, a 3-bit `opt` and an `equ` select. The block arbitrates round-robin, registers the winner's operands onto the datapath inputs and holds them for a configurable multicycle window. It then captures the 10-bit result and returns it with a requester ID over a valid/ready response port. It sits between the lab's job sources and a single shared CC instance.

---
 rtl/cc_job_scheduler_if.sv | 53 +++++
 rtl/cc_job_scheduler.sv | 101 ++++++++++
 tb/tb_cc_job_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_job_scheduler_if.sv
// Request, datapath and response signals of the shared CC job scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface cc_job_scheduler_if #(
    parameter int OUT_W = 10
);
    logic             req0_valid;
    logic             req0_ready;
    logic [23:0]      req0_data;
    logic [2:0]       req0_opt;
    logic             req0_equ;

    logic             req1_valid;
    logic             req1_ready;
    logic [23:0]      req1_data;
    logic [2:0]       req1_opt;
    logic             req1_equ;

    logic [23:0]      cc_in;
    logic [2:0]       cc_opt;
    logic             cc_equ;
    logic [OUT_W-1:0] cc_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [OUT_W-1:0] rsp_data;
    logic             rsp_id;

    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_opt, req0_equ,
        output req0_ready,
        input  req1_valid, req1_data, req1_opt, req1_equ,
        output req1_ready,
        output cc_in, cc_opt, cc_equ,
        input  cc_out,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_data, req0_opt, req0_equ,
        input  req0_ready,
        output req1_valid, req1_data, req1_opt, req1_equ,
        input  req1_ready,
        input  cc_in, cc_opt, cc_equ,
        output cc_out,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/cc_job_scheduler.sv
// Round-robin scheduler sharing one combinational CC datapath between two
// requesters; operands are held for CALC_CYCLES before the result is captured.
module cc_job_scheduler #(
    parameter int CALC_CYCLES = 1,
    parameter int OUT_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    cc_job_scheduler_if.slave   bus
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant;
    logic             handshake;

    logic [23:0]      cc_in_q;
    logic [2:0]       cc_opt_q;
    logic             cc_equ_q;
    logic             rsp_valid_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic             rsp_id_q;

    // NOTE: every path assigns grant, so this always_comb cannot infer a latch.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign handshake      = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = handshake && !grant;
    assign bus.req1_ready = handshake && grant;
    assign bus.busy       = (state != IDLE) && !rst;

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            cc_in_q     <= '0;
            cc_opt_q    <= '0;
            cc_equ_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (handshake) begin
                        cc_in_q    <= grant ? bus.req1_data : bus.req0_data;
                        cc_opt_q   <= grant ? bus.req1_opt  : bus.req0_opt;
                        cc_equ_q   <= grant ? bus.req1_equ  : bus.req0_equ;
                        rsp_id_q   <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_W'(CALC_CYCLES - 1);
                        state      <= CALC;
                    end
                end
                CALC: begin
                    // The datapath is a multicycle path; sample only at the end of the window.
                    if (cnt == '0) begin
                        rsp_data_q  <= bus.cc_out;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cc_in     = cc_in_q;
    assign bus.cc_opt    = cc_opt_q;
    assign bus.cc_equ    = cc_equ_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cc_job_scheduler.sv
// Self-checking bench for cc_job_scheduler: directed scenarios on CALC_CYCLES=1
// and 4 instances plus a randomized run against a transaction-level model.
module tb_cc_job_scheduler;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    cc_job_scheduler_if #(.OUT_W(10)) bus1 ();
    cc_job_scheduler_if #(.OUT_W(10)) bus4 ();

    assign bus1.cc_out = {bus1.cc_equ, bus1.cc_opt, bus1.cc_in[5:0]};
    assign bus4.cc_out = {bus4.cc_equ, bus4.cc_opt, bus4.cc_in[5:0]};

    cc_job_scheduler #(.CALC_CYCLES(1), .OUT_W(10)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    cc_job_scheduler #(.CALC_CYCLES(4), .OUT_W(10)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4.slave)
    );

    function automatic logic [9:0] stub(input logic [23:0] d, input logic [2:0] o, input logic e);
        return {e, o, d[5:0]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v0, input logic [23:0] d0, input logic [2:0] o0, input logic e0,
                          input logic v1, input logic [23:0] d1, input logic [2:0] o1, input logic e1,
                          input logic rr);
        bus1.req0_valid = v0; bus1.req0_data = d0; bus1.req0_opt = o0; bus1.req0_equ = e0;
        bus1.req1_valid = v1; bus1.req1_data = d1; bus1.req1_opt = o1; bus1.req1_equ = e1;
        bus1.rsp_ready  = rr;
    endtask

    task automatic reset1();
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst1 = 1'b1;
        next_cycle();
        next_cycle();
        rst1 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        rst4 = 1'b1;
        drive1(1, 24'hABCDEF, 3'd7, 1, 1, 24'h123456, 3'd2, 0, 1);
        bus4.req0_valid = 1'b1; bus4.req0_data = 24'h111111; bus4.req0_opt = 3'd1; bus4.req0_equ = 1'b0;
        bus4.req1_valid = 1'b1; bus4.req1_data = 24'h222222; bus4.req1_opt = 3'd2; bus4.req1_equ = 1'b1;
        bus4.rsp_ready  = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        tests_run++; if (bus1.req0_ready !== 1'b0 || bus1.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b%b exp=00", bus1.req0_ready, bus1.req1_ready); end
        tests_run++; if (bus1.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus1.busy); end
        tests_run++; if ({bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id} !== 12'h0) begin tests_failed++; $display("FAIL reset_rsp got=%h exp=0", {bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id}); end
        tests_run++; if ({bus1.cc_in, bus1.cc_opt, bus1.cc_equ} !== 28'h0) begin tests_failed++; $display("FAIL reset_cc got=%h exp=0", {bus1.cc_in, bus1.cc_opt, bus1.cc_equ}); end
        tests_run++; if ({bus4.req0_ready, bus4.req1_ready, bus4.busy, bus4.rsp_valid} !== 4'h0) begin tests_failed++; $display("FAIL reset_dut4 got=%b exp=0000", {bus4.req0_ready, bus4.req1_ready, bus4.busy, bus4.rsp_valid}); end
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b0;
        next_cycle();
        rst1 = 1'b0;
        rst4 = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_job();
        drive1(1, 24'h654321, 3'b101, 1, 0, 0, 0, 0, 1);
        #1;
        tests_run++; if (bus1.req0_ready !== 1'b1 || bus1.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL single_grant got=%b%b exp=10", bus1.req0_ready, bus1.req1_ready); end
        next_cycle();
        drive1(0, 24'h0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        tests_run++; if ({bus1.cc_in, bus1.cc_opt, bus1.cc_equ} !== {24'h654321, 3'b101, 1'b1}) begin tests_failed++; $display("FAIL single_cc got=%h exp=%h", {bus1.cc_in, bus1.cc_opt, bus1.cc_equ}, {24'h654321, 3'b101, 1'b1}); end
        tests_run++; if (bus1.busy !== 1'b1 || bus1.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_calc busy=%b rsp_valid=%b exp=1/0", bus1.busy, bus1.rsp_valid); end
        next_cycle();
        #1;
        tests_run++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== 10'h361 || bus1.rsp_id !== 1'b0) begin tests_failed++; $display("FAIL single_rsp got=%b/%h/%b exp=1/361/0", bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id); end
        next_cycle();
        #1;
        tests_run++; if (bus1.busy !== 1'b0 || bus1.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle busy=%b rsp_valid=%b exp=0/0", bus1.busy, bus1.rsp_valid); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic       e_r0, e_r1, e_v, e_id;
        logic [9:0] e_d;
        reset1();
        for (int c = 0; c < 12; c++) begin
            drive1(1, 24'h000011, 0, 0, 1, 24'h000022, 0, 0, 1);
            #1;
            e_r0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            e_r1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            e_v  = (c % 3 == 2);
            e_id = ((c / 3) % 2 == 1);
            e_d  = e_id ? 10'h022 : 10'h011;
            tests_run++; if (bus1.req0_ready !== e_r0 || bus1.req1_ready !== e_r1) begin tests_failed++; $display("FAIL contention_grant c=%0d got=%b%b exp=%b%b", c, bus1.req0_ready, bus1.req1_ready, e_r0, e_r1); end
            tests_run++; if (bus1.rsp_valid !== e_v) begin tests_failed++; $display("FAIL contention_valid c=%0d got=%b exp=%b", c, bus1.rsp_valid, e_v); end
            if (e_v) begin
                tests_run++; if (bus1.rsp_data !== e_d || bus1.rsp_id !== e_id) begin tests_failed++; $display("FAIL contention_rsp c=%0d got=%h/%b exp=%h/%b", c, bus1.rsp_data, bus1.rsp_id, e_d, e_id); end
            end
            next_cycle();
        end
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [23:0] d;
        logic [2:0]  o;
        logic        e;
        logic [9:0]  exp_d;
        d = 24'($urandom);
        o = 3'($urandom);
        e = 1'($urandom);
        exp_d = stub(d, o, e);
        drive1(1, d, o, e, 0, 0, 0, 0, 0);
        #1;
        tests_run++; if (bus1.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_grant got=%b exp=1", bus1.req0_ready); end
        next_cycle();
        drive1(1, ~d, 0, 0, 1, d, 0, 0, 0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== exp_d || bus1.rsp_id !== 1'b0) begin tests_failed++; $display("FAIL bp_hold c=%0d got=%b/%h/%b exp=1/%h/0", c, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id, exp_d); end
            tests_run++; if (bus1.req0_ready !== 1'b0 || bus1.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready c=%0d got=%b%b exp=00", c, bus1.req0_ready, bus1.req1_ready); end
            next_cycle();
        end
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        tests_run++; if (bus1.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_release got=%b exp=1", bus1.rsp_valid); end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            tests_run++; if (bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle c=%0d rsp_valid=%b busy=%b exp=0/0", c, bus1.rsp_valid, bus1.busy); end
        end
        next_cycle();
    endtask

    task automatic test_multicycle();
        logic [23:0] d;
        logic [2:0]  o;
        logic        e;
        d = 24'($urandom);
        o = 3'($urandom);
        e = 1'($urandom);
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b1; bus4.req1_data = d; bus4.req1_opt = o; bus4.req1_equ = e;
        bus4.rsp_ready  = 1'b1;
        #1;
        tests_run++; if (bus4.req1_ready !== 1'b1 || bus4.req0_ready !== 1'b0) begin tests_failed++; $display("FAIL mc_grant got=%b%b exp=01", bus4.req0_ready, bus4.req1_ready); end
        next_cycle();
        bus4.req1_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                bus4.req1_data = ~d; bus4.req1_opt = ~o; bus4.req1_equ = ~e;
            end
            #1;
            tests_run++; if ({bus4.cc_in, bus4.cc_opt, bus4.cc_equ} !== {d, o, e}) begin tests_failed++; $display("FAIL mc_cc_hold c=%0d got=%h exp=%h", c, {bus4.cc_in, bus4.cc_opt, bus4.cc_equ}, {d, o, e}); end
            tests_run++; if (bus4.rsp_valid !== 1'b0 || bus4.busy !== 1'b1) begin tests_failed++; $display("FAIL mc_calc c=%0d rsp_valid=%b busy=%b exp=0/1", c, bus4.rsp_valid, bus4.busy); end
            next_cycle();
        end
        #1;
        tests_run++; if (bus4.rsp_valid !== 1'b1 || bus4.rsp_data !== stub(d, o, e) || bus4.rsp_id !== 1'b1) begin tests_failed++; $display("FAIL mc_rsp got=%b/%h/%b exp=1/%h/1", bus4.rsp_valid, bus4.rsp_data, bus4.rsp_id, stub(d, o, e)); end
        next_cycle();
        #1;
        tests_run++; if (bus4.rsp_valid !== 1'b0 || bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL mc_idle rsp_valid=%b busy=%b exp=0/0", bus4.rsp_valid, bus4.busy); end
        next_cycle();
    endtask

    task automatic test_reset_mid_calc();
        drive1(1, 24'h00003F, 3'd6, 1, 0, 0, 0, 0, 1);
        #1;
        tests_run++; if (bus1.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL rmc_grant got=%b exp=1", bus1.req0_ready); end
        next_cycle();
        drive1(1, 0, 0, 0, 1, 0, 0, 0, 1);
        rst1 = 1'b1;
        #1;
        tests_run++; if (bus1.busy !== 1'b0 || bus1.req0_ready !== 1'b0 || bus1.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rmc_in_reset busy=%b ready=%b%b exp=0/00", bus1.busy, bus1.req0_ready, bus1.req1_ready); end
        next_cycle();
        rst1 = 1'b0;
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        tests_run++; if ({bus1.busy, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id} !== 13'h0) begin tests_failed++; $display("FAIL rmc_rsp_cleared got=%h exp=0", {bus1.busy, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_id}); end
        tests_run++; if ({bus1.cc_in, bus1.cc_opt, bus1.cc_equ} !== 28'h0) begin tests_failed++; $display("FAIL rmc_cc_cleared got=%h exp=0", {bus1.cc_in, bus1.cc_opt, bus1.cc_equ}); end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #1;
            tests_run++; if (bus1.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rmc_no_rsp c=%0d got=%b exp=0", c, bus1.rsp_valid); end
        end
        next_cycle();
        drive1(1, 24'h000005, 0, 0, 1, 24'h000006, 0, 0, 1);
        #1;
        tests_run++; if (bus1.req0_ready !== 1'b1 || bus1.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rmc_pointer got=%b%b exp=10", bus1.req0_ready, bus1.req1_ready); end
        next_cycle();
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_withdrawn();
        int n_rsp = 0;
        drive1(1, 24'h000001, 0, 0, 0, 0, 0, 0, 1);
        #1;
        tests_run++; if (bus1.req0_ready !== 1'b1) begin tests_failed++; $display("FAIL wd_grant got=%b exp=1", bus1.req0_ready); end
        next_cycle();
        drive1(0, 0, 0, 0, 1, 24'h000002, 0, 0, 1);
        for (int c = 1; c < 10; c++) begin
            #1;
            tests_run++; if (bus1.req1_ready !== 1'b0) begin tests_failed++; $display("FAIL wd_req1_ready c=%0d got=%b exp=0", c, bus1.req1_ready); end
            if (bus1.rsp_valid === 1'b1) begin
                n_rsp++;
                tests_run++; if (bus1.rsp_id !== 1'b0) begin tests_failed++; $display("FAIL wd_rsp_id c=%0d got=%b exp=0", c, bus1.rsp_id); end
            end
            next_cycle();
            drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        tests_run++; if (n_rsp != 1) begin tests_failed++; $display("FAIL wd_rsp_count got=%0d exp=1", n_rsp); end
    endtask

    // Transaction-level reference: a job is granted from idle by the round-robin
    // rule, its response appears CALC_CYCLES+1 cycles later and waits for rsp_ready.
    task automatic test_random();
        localparam int CALC = 1;
        bit          m_idle = 1'b1;
        bit          m_resp = 1'b0;
        bit          m_last = 1'b1;
        int          m_wait = 0;
        logic [23:0] m_in;
        logic [2:0]  m_opt;
        logic        m_equ;
        logic        m_id;
        int          n_rsp = 0;
        logic        v0, v1, e0, e1, rr, e_r0, e_r1;
        logic [23:0] d0, d1;
        logic [2:0]  o0, o1;
        reset1();
        for (int c = 0; c < 400; c++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 9) < 7);
            d0 = 24'($urandom); d1 = 24'($urandom);
            o0 = 3'($urandom);  o1 = 3'($urandom);
            e0 = 1'($urandom);  e1 = 1'($urandom);
            drive1(v0, d0, o0, e0, v1, d1, o1, e1, rr);
            #1;
            e_r0 = m_idle && v0 && (!v1 || m_last);
            e_r1 = m_idle && v1 && (!v0 || !m_last);
            tests_run++; if (bus1.req0_ready !== e_r0 || bus1.req1_ready !== e_r1) begin tests_failed++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, bus1.req0_ready, bus1.req1_ready, e_r0, e_r1); end
            tests_run++; if (bus1.busy !== !m_idle || bus1.rsp_valid !== m_resp) begin tests_failed++; $display("FAIL rnd_status c=%0d busy=%b rsp_valid=%b exp=%b/%b", c, bus1.busy, bus1.rsp_valid, !m_idle, m_resp); end
            if (m_resp) begin
                tests_run++; if (bus1.rsp_data !== stub(m_in, m_opt, m_equ) || bus1.rsp_id !== m_id) begin tests_failed++; $display("FAIL rnd_rsp c=%0d got=%h/%b exp=%h/%b", c, bus1.rsp_data, bus1.rsp_id, stub(m_in, m_opt, m_equ), m_id); end
            end
            if (!m_idle) begin
                tests_run++; if ({bus1.cc_in, bus1.cc_opt, bus1.cc_equ} !== {m_in, m_opt, m_equ}) begin tests_failed++; $display("FAIL rnd_cc c=%0d got=%h exp=%h", c, {bus1.cc_in, bus1.cc_opt, bus1.cc_equ}, {m_in, m_opt, m_equ}); end
            end
            if (m_idle) begin
                if (e_r0 || e_r1) begin
                    m_id   = e_r1;
                    m_last = e_r1;
                    m_in   = e_r1 ? d1 : d0;
                    m_opt  = e_r1 ? o1 : o0;
                    m_equ  = e_r1 ? e1 : e0;
                    m_idle = 1'b0;
                    m_wait = CALC;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_resp = 1'b1;
            end else if (m_resp && rr) begin
                m_resp = 1'b0;
                m_idle = 1'b1;
                n_rsp++;
            end
            next_cycle();
        end
        tests_run++; if (n_rsp < 20) begin tests_failed++; $display("FAIL rnd_activity got=%0d responses exp>=20", n_rsp); end
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_backpressure();
        test_multicycle();
        test_reset_mid_calc();
        test_withdrawn();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
